simd_pipe_core: RTL and testbench

- Parametrised, pipelined successor to the fixed 4-lane combinational SIMD core.
- LANES identical lanes, each with W-bit unsigned operands and a 2W-bit result, sharing one opcode per beat.
- Adds valid/ready handshake, per-lane enable mask, and a per-lane multiply-accumulate register.
- Sits between the operand fetch stage and the result writeback buffer.

---
 rtl/simd_pkg.sv | 11 +
 rtl/simd_lane.sv | 103 ++++++++++
 rtl/simd_pipe_core.sv | 97 +++++++++
 tb/tb_simd_pipe_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: opcode encoding shared by the SIMD pipeline core and its lanes.
package simd_pkg;

   typedef logic [1:0] simd_op_t;

   localparam simd_op_t OP_ADD = 2'b00;
   localparam simd_op_t OP_SUB = 2'b01;
   localparam simd_op_t OP_MUL = 2'b10;
   localparam simd_op_t OP_MAC = 2'b11;

endpackage

// File: rtl/simd_lane.sv
// simd_lane: one SIMD lane -- ALU, multiply-accumulate register and sticky
// overflow flag. Optional MAC saturation is enabled by SIMD_PIPE_MAC_SAT_EN;
// without it MAC wraps and the overflow flag is a constant 0.
module simd_lane
   import simd_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             mask_i,
   input  logic             clr_i,
   input  logic [1:0]       op_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   output logic [2*W-1:0]   result_o,
   output logic             ovf_o
);

   logic [2*W-1:0] aExt;
   logic [2*W-1:0] bExt;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] base;
   logic [2*W-1:0] macRes;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] acc_d;

   assign aExt = {{W{1'b0}}, a_i};
   assign bExt = {{W{1'b0}}, b_i};
   assign prod = aExt * bExt;
   assign base = clr_i ? '0 : acc_q;

`ifdef SIMD_PIPE_MAC_SAT_EN
   logic [2*W:0] macSum;
   logic         ovf_q;
   logic         ovf_d;

   assign macSum = {1'b0, base} + {1'b0, prod};
   assign macRes = macSum[2*W] ? '1 : macSum[2*W-1:0];

   // Sticky overflow: a clearing beat restarts it, a carry out of the MAC sets it
   always_comb begin
      ovf_d = ovf_q;
      if (en_i && mask_i) begin
         if (op_i == OP_MAC) begin
            ovf_d = (clr_i ? 1'b0 : ovf_q) | macSum[2*W];
         end else if (clr_i) begin
            ovf_d = 1'b0;
         end
      end
   end

   // Overflow flag register, zeroed by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;
`else
   assign macRes = base + prod;
   assign ovf_o  = 1'b0;
`endif

   // Lane result; a masked lane always reads zero
   always_comb begin
      result_o = '0;
      if (mask_i) begin
         case (op_i)
            OP_ADD:  result_o = aExt + bExt;
            OP_SUB:  result_o = aExt - bExt;
            OP_MUL:  result_o = prod;
            default: result_o = macRes;
         endcase
      end
   end

   // Accumulator moves only when a valid unmasked beat leaves S1
   always_comb begin
      acc_d = acc_q;
      if (en_i && mask_i) begin
         if (op_i == OP_MAC) begin
            acc_d = macRes;
         end else if (clr_i) begin
            acc_d = '0;
         end
      end
   end

   // Accumulator register, zeroed by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/simd_pipe_core.sv
// simd_pipe_core: two-stage SIMD pipeline with valid/ready handshake, lane
// mask and per-lane MAC accumulators. Define SIMD_PIPE_MAC_SAT_EN to make MAC
// saturate and drive the sticky out_ovf flags; otherwise out_ovf is 0.
module simd_pipe_core
   import simd_pkg::*;
#(
   parameter int LANES = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_op,
   input  logic                   in_acc_clr,
   input  logic [LANES-1:0]       in_mask,
   input  logic [LANES*W-1:0]     in_a,
   input  logic [LANES*W-1:0]     in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*2*W-1:0]   out_data,
   output logic [LANES-1:0]       out_ovf
);

   logic                   adv;
   logic                   s1Valid_q;
   logic [1:0]             s1Op_q;
   logic                   s1Clr_q;
   logic [LANES-1:0]       s1Mask_q;
   logic [LANES*W-1:0]     s1A_q;
   logic [LANES*W-1:0]     s1B_q;
   logic                   outValid_q;
   logic [LANES*2*W-1:0]   outData_q;
   logic [LANES*2*W-1:0]   laneRes;
   logic                   laneEn;

   // The whole pipe moves together unless a result is waiting on downstream
   assign adv       = !outValid_q || out_ready;
   assign in_ready  = adv;
   assign laneEn    = adv && s1Valid_q;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   // S1: capture the accepted beat; a missing beat becomes a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Op_q    <= OP_ADD;
         s1Clr_q   <= 1'b0;
         s1Mask_q  <= '0;
         s1A_q     <= '0;
         s1B_q     <= '0;
      end else if (adv) begin
         s1Valid_q <= in_valid;
         if (in_valid) begin
            s1Op_q   <= in_op;
            s1Clr_q  <= in_acc_clr;
            s1Mask_q <= in_mask;
            s1A_q    <= in_a;
            s1B_q    <= in_b;
         end
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : gLane
         simd_lane #(
            .W (W)
         ) uLane (
            .clk      (clk),
            .rst      (rst),
            .en_i     (laneEn),
            .mask_i   (s1Mask_q[i]),
            .clr_i    (s1Clr_q),
            .op_i     (s1Op_q),
            .a_i      (s1A_q[i*W +: W]),
            .b_i      (s1B_q[i*W +: W]),
            .result_o (laneRes[i*2*W +: 2*W]),
            .ovf_o    (out_ovf[i])
         );
      end
   endgenerate

   // S2: register lane results; data is held across bubbles and stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else if (adv) begin
         outValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            outData_q <= laneRes;
         end
      end
   end

endmodule

// File: tb/tb_simd_pipe_core.sv
// tb_simd_pipe_core: directed-vector scoreboard bench for simd_pipe_core
// (LANES=4, W=8). Expectations follow SIMD_PIPE_MAC_SAT_EN when defined.
module tb_simd_pipe_core;
   import simd_pkg::*;

   localparam int LANES = 4;
   localparam int W     = 8;

`ifdef SIMD_PIPE_MAC_SAT_EN
   localparam logic [15:0] OVF_RES  = 16'hFFFF;
   localparam logic [3:0]  OVF_FLAG = 4'hF;
`else
   localparam logic [15:0] OVF_RES  = 16'hFC02;
   localparam logic [3:0]  OVF_FLAG = 4'h0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           in_op;
   logic                 in_acc_clr;
   logic [LANES-1:0]     in_mask;
   logic [LANES*W-1:0]   in_a;
   logic [LANES*W-1:0]   in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*2*W-1:0] out_data;
   logic [LANES-1:0]     out_ovf;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  ovf;
      bit          chkLat;
      int          idx;
      string       name;
   } exp_t;

   exp_t sbQ[$];
   int   checks   = 0;
   int   fails    = 0;
   int   negCount = 0;

   always #5 clk = ~clk;

   always @(negedge clk) negCount <= negCount + 1;

   simd_pipe_core #(
      .LANES (LANES),
      .W     (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_acc_clr (in_acc_clr),
      .in_mask    (in_mask),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf)
   );

   // Replicate one lane value into every enabled lane
   function automatic logic [63:0] rep(input logic [15:0] v, input logic [3:0] m);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         if (m[i]) r[i*16 +: 16] = v;
      end
      return r;
   endfunction

   // Single comparison point: counts and reports
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer one beat, wait (bounded) for acceptance, then queue its expectation
   task automatic applyStimulus(input string name, input logic [1:0] op, input logic clr,
                                input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] expLane, input logic [3:0] expOvf,
                                input bit push, input bit lat);
      int   budget;
      exp_t e;
      @(negedge clk);
      in_valid   = 1'b1;
      in_op      = op;
      in_acc_clr = clr;
      in_mask    = mask;
      in_a       = {4{a}};
      in_b       = {4{b}};
      #1;
      budget = 0;
      while (!in_ready && budget < 50) begin
         @(negedge clk);
         #1;
         budget++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s accept: in_ready got %b, expected 1", name, in_ready);
         in_valid = 1'b0;
         return;
      end
      e.data   = rep(expLane, mask);
      e.ovf    = expOvf;
      e.chkLat = lat;
      e.idx    = negCount;
      e.name   = name;
      @(posedge clk);
      if (push) sbQ.push_back(e);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for every queued expectation to be consumed
   task automatic waitDrain(input string name);
      int b;
      b = 0;
      while ((sbQ.size() != 0 || out_valid) && b < 100) begin
         @(negedge clk);
         #1;
         b++;
      end
      if (sbQ.size() != 0 || out_valid) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s drain: %0d results outstanding, expected 0", name, sbQ.size());
      end
   endtask

   // Monitor: compare every transferred output beat against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected out_valid: data %h, expected no beat", out_data);
            end else begin
               e = sbQ.pop_front();
               checkOutput({e.name, " data"}, out_data, e.data);
               checkOutput({e.name, " ovf"}, {60'b0, out_ovf}, {60'b0, e.ovf});
               if (e.chkLat) begin
                  checkOutput({e.name, " latency"}, 64'(negCount - e.idx), 64'd2);
               end
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_op      = OP_ADD;
      in_acc_clr = 1'b0;
      in_mask    = '0;
      in_a       = '0;
      in_b       = '0;
      out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("reset out_data", out_data, 64'd0);
      checkOutput("reset out_ovf", {60'b0, out_ovf}, 64'd0);
      checkOutput("reset in_ready", {63'b0, in_ready}, 64'd1);

      $display("[TB] basic ALU ops");
      applyStimulus("add", OP_ADD, 1'b0, 4'hF, 8'd200, 8'd100, 16'h012C, 4'h0, 1, 1);
      waitDrain("add");
      applyStimulus("sub", OP_SUB, 1'b0, 4'hF, 8'd5, 8'd7, 16'hFFFE, 4'h0, 1, 0);
      applyStimulus("mul", OP_MUL, 1'b0, 4'hF, 8'd255, 8'd255, 16'hFE01, 4'h0, 1, 0);
      applyStimulus("mul masked", OP_MUL, 1'b0, 4'b0101, 8'd255, 8'd255, 16'hFE01, 4'h0, 1, 0);

      $display("[TB] MAC chain");
      applyStimulus("mac clr 10*10", OP_MAC, 1'b1, 4'hF, 8'd10, 8'd10, 16'd100, 4'h0, 1, 0);
      applyStimulus("mac 20*3", OP_MAC, 1'b0, 4'hF, 8'd20, 8'd3, 16'd160, 4'h0, 1, 0);
      applyStimulus("add clr", OP_ADD, 1'b1, 4'hF, 8'd1, 8'd2, 16'd3, 4'h0, 1, 0);
      applyStimulus("mac 1*1", OP_MAC, 1'b0, 4'hF, 8'd1, 8'd1, 16'd1, 4'h0, 1, 0);

      $display("[TB] MAC overflow");
      applyStimulus("mac clr 255*255", OP_MAC, 1'b1, 4'hF, 8'd255, 8'd255, 16'hFE01, 4'h0, 1, 0);
      applyStimulus("mac ovf 255*255", OP_MAC, 1'b0, 4'hF, 8'd255, 8'd255, OVF_RES, OVF_FLAG, 1, 0);
      applyStimulus("add ovf sticky", OP_ADD, 1'b0, 4'hF, 8'd1, 8'd1, 16'd2, OVF_FLAG, 1, 0);
      applyStimulus("mac clr 2*2", OP_MAC, 1'b1, 4'hF, 8'd2, 8'd2, 16'd4, 4'h0, 1, 0);
      waitDrain("mac");

      $display("[TB] backpressure");
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            applyStimulus("bp mac 1", OP_MAC, 1'b0, 4'hF, 8'd1, 8'd1, 16'd5, 4'h0, 1, 0);
            applyStimulus("bp mac 2", OP_MAC, 1'b0, 4'hF, 8'd1, 8'd1, 16'd6, 4'h0, 1, 0);
            applyStimulus("bp mac 3", OP_MAC, 1'b0, 4'hF, 8'd1, 8'd1, 16'd7, 4'h0, 1, 0);
         end
         begin
            int          b;
            logic [63:0] held;
            b = 0;
            do begin
               @(negedge clk);
               #1;
               b++;
            end while (!out_valid && b < 20);
            checkOutput("bp valid pending", {63'b0, out_valid}, 64'd1);
            checkOutput("bp in_ready low", {63'b0, in_ready}, 64'd0);
            held = out_data;
            repeat (2) begin
               @(negedge clk);
               #1;
               checkOutput("bp data stable", out_data, held);
               checkOutput("bp in_ready held", {63'b0, in_ready}, 64'd0);
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      waitDrain("bp");

      $display("[TB] reset with beats in flight");
      applyStimulus("rst beat 1", OP_MAC, 1'b1, 4'hF, 8'd7, 8'd7, 16'd49, 4'h0, 0, 0);
      applyStimulus("rst beat 2", OP_MAC, 1'b0, 4'hF, 8'd2, 8'd2, 16'd53, 4'h0, 0, 0);
      rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("async rst out_data", out_data, 64'd0);
      checkOutput("async rst out_ovf", {60'b0, out_ovf}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus("mac after rst 3*3", OP_MAC, 1'b0, 4'hF, 8'd3, 8'd3, 16'd9, 4'h0, 1, 0);
      waitDrain("post rst");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
